mem_write_dma: RTL and testbench

Write-side DMA engine between the command/stream front-end and the AXI4 memory port. Accepts one write command (address, byte length) on an `axis_mem_cmd` slave and pulls the matching payload from an `axi_stream` slave. Emits AXI4 INCR write bursts on an `axi_mm` master, never crossing a 4 KB boundary. Returns one completion byte per command on an `axis_mem_status` master once all write responses are back.

---
 rtl/mem_write_dma_if.sv | 113 +++++++++++
 rtl/mem_write_dma.sv | 180 ++++++++++++++++++
 tb/tb_mem_write_dma.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_dma_if.sv
// Bus bundles used by mem_write_dma: write command, payload stream,
// AXI4 memory port and completion status.

interface axis_mem_cmd;
    logic        valid;
    logic        ready;
    logic [63:0] addr;
    logic [31:0] len;

    modport master (output valid, addr, len, input ready);
    modport slave  (input valid, addr, len, output ready);
endinterface

interface axi_stream #(
    parameter int DATA_WIDTH = 512
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    last;

    modport master (output valid, data, keep, last, input ready);
    modport slave  (input valid, data, keep, last, output ready);
endinterface

interface axi_mm #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic [USER_WIDTH-1:0]   awuser;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [USER_WIDTH-1:0]   wuser;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic [USER_WIDTH-1:0]   buser;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic [USER_WIDTH-1:0]   aruser;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [USER_WIDTH-1:0]   ruser;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
               wdata, wstrb, wlast, wuser, wvalid,
               bready,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
               rready,
        input  awready, wready, bid, bresp, buser, bvalid, arready,
               rid, rdata, rresp, rlast, ruser, rvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
               wdata, wstrb, wlast, wuser, wvalid,
               bready,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
               rready,
        output awready, wready, bid, bresp, buser, bvalid, arready,
               rid, rdata, rresp, rlast, ruser, rvalid
    );
endinterface

interface axis_mem_status;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport master (output valid, data, input ready);
    modport slave  (input valid, data, output ready);
endinterface

// File: rtl/mem_write_dma.sv
// Write-side DMA: one command at a time, split into 4 KB-safe AXI4 INCR bursts,
// payload passed straight through from the stream, one status byte per command.

module mem_write_dma #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 512,
    parameter int MAX_BURST  = 64
) (
    input  logic           clk,
    input  logic           rstn,
    axis_mem_cmd.slave     s_cmd,
    axi_stream.slave       s_data,
    axi_mm.master          m_axi,
    axis_mem_status.master m_status
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int LOG_BYTES  = $clog2(BYTES);
    localparam int PAGE_BEATS = 4096 / BYTES;

    typedef enum logic [2:0] {IDLE, AW, W, WAIT_B, STATUS} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           beats_rem;
    logic [7:0]            beat_idx;
    logic [26:0]           bursts_out;
    logic                  err;
    logic                  cmd_ready;

    logic [32:0]           cmd_beats;
    logic [31:0]           page_beats;
    logic [31:0]           burst_full;
    logic [8:0]            burst;
    logic                  last_beat;
    logic                  bready;
    logic                  cmd_hs;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  st_hs;

    assign cmd_beats  = (33'(s_cmd.len) + 33'(BYTES - 1)) >> LOG_BYTES;
    assign page_beats = 32'(PAGE_BEATS) - 32'(addr[11:LOG_BYTES]);

    // Burst length is the tightest of remaining beats, 4 KB page room and MAX_BURST.
    always_comb begin
        burst_full = beats_rem;
        if (page_beats < burst_full)
            burst_full = page_beats;
        if (32'(MAX_BURST) < burst_full)
            burst_full = 32'(MAX_BURST);
    end

    assign burst     = burst_full[8:0];
    assign last_beat = (beat_idx == 8'(burst - 9'd1));
    assign bready    = (state inside {AW, W, WAIT_B});

    assign cmd_hs = cmd_ready & s_cmd.valid;
    assign aw_hs  = (state == AW) & m_axi.awready;
    assign w_hs   = (state == W) & s_data.valid & m_axi.wready;
    assign b_hs   = bready & m_axi.bvalid;
    assign st_hs  = (state == STATUS) & m_status.ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_hs)
                    state_nxt = (s_cmd.len == '0) ? STATUS : AW;
            end
            AW: begin
                if (aw_hs)
                    state_nxt = W;
            end
            W: begin
                if (w_hs && last_beat)
                    state_nxt = (beats_rem != 32'(burst)) ? AW : WAIT_B;
            end
            WAIT_B: begin
                // Leave on the final B itself so status follows it by one cycle.
                if (bursts_out == '0 || (bursts_out == 27'd1 && b_hs))
                    state_nxt = STATUS;
            end
            STATUS: begin
                if (st_hs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            addr       <= '0;
            beats_rem  <= '0;
            beat_idx   <= '0;
            bursts_out <= '0;
            err        <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);

            if (cmd_hs) begin
                addr      <= {s_cmd.addr[ADDR_WIDTH-1:LOG_BYTES], {LOG_BYTES{1'b0}}};
                beats_rem <= cmd_beats[31:0];
            end else if (w_hs && last_beat) begin
                addr      <= addr + (ADDR_WIDTH'(burst) << LOG_BYTES);
                beats_rem <= beats_rem - 32'(burst);
            end

            if (cmd_hs)
                beat_idx <= '0;
            else if (w_hs)
                beat_idx <= last_beat ? '0 : beat_idx + 8'd1;

            // Simultaneous AW issue and B retire cancel out.
            if (cmd_hs)
                bursts_out <= '0;
            else if (aw_hs && !b_hs)
                bursts_out <= bursts_out + 27'd1;
            else if (b_hs && !aw_hs)
                bursts_out <= bursts_out - 27'd1;

            if (cmd_hs)
                err <= 1'b0;
            else if (b_hs && m_axi.bresp != 2'b00)
                err <= 1'b1;
        end
    end

    assign s_cmd.ready = cmd_ready;

    assign m_axi.awvalid  = (state == AW);
    assign m_axi.awaddr   = addr;
    assign m_axi.awlen    = 8'(burst - 9'd1);
    assign m_axi.awsize   = 3'(LOG_BYTES);
    assign m_axi.awburst  = 2'b01;
    assign m_axi.awid     = '0;
    assign m_axi.awlock   = 1'b0;
    assign m_axi.awcache  = '0;
    assign m_axi.awprot   = '0;
    assign m_axi.awqos    = '0;
    assign m_axi.awregion = '0;
    assign m_axi.awuser   = '0;

    assign m_axi.wvalid = (state == W) & s_data.valid;
    assign s_data.ready = (state == W) & m_axi.wready;
    assign m_axi.wdata  = s_data.data;
    assign m_axi.wstrb  = s_data.keep;
    assign m_axi.wlast  = (state == W) & last_beat;
    assign m_axi.wuser  = '0;

    assign m_axi.bready = bready;

    assign m_axi.arid     = '0;
    assign m_axi.araddr   = '0;
    assign m_axi.arlen    = '0;
    assign m_axi.arsize   = '0;
    assign m_axi.arburst  = '0;
    assign m_axi.arlock   = 1'b0;
    assign m_axi.arcache  = '0;
    assign m_axi.arprot   = '0;
    assign m_axi.arqos    = '0;
    assign m_axi.arregion = '0;
    assign m_axi.aruser   = '0;
    assign m_axi.arvalid  = 1'b0;
    assign m_axi.rready   = 1'b0;

    assign m_status.valid = (state == STATUS);
    assign m_status.data  = {7'b0, err};

    logic unused_inputs;
    assign unused_inputs = ^{s_cmd.addr, s_data.last, m_axi.bid, m_axi.buser,
                             m_axi.arready, m_axi.rid, m_axi.rdata, m_axi.rresp,
                             m_axi.rlast, m_axi.ruser, m_axi.rvalid,
                             cmd_beats[32], burst_full[31:9]};
endmodule

// File: tb/tb_mem_write_dma.sv
// Self-checking bench for mem_write_dma: acts as stream source, AXI slave and
// status sink, comparing every transaction against a burst-splitting reference.

module tb_mem_write_dma;
    localparam int AW    = 33;
    localparam int DW    = 512;
    localparam int MB    = 64;
    localparam int BYTES = DW / 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axis_mem_cmd                                  cmd_if ();
    axi_stream #(.DATA_WIDTH(DW))                 data_if ();
    axi_mm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW))    mm_if ();
    axis_mem_status                               st_if ();

    mem_write_dma #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_cmd   (cmd_if),
        .s_data  (data_if),
        .m_axi   (mm_if),
        .m_status(st_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [63:0]  exp_addr[$];
    int           exp_len[$];
    bit           exp_last[$];
    logic [511:0] pay[$];
    logic [63:0]  kp[$];
    logic [63:0]  obs_addr[$];
    int           obs_len[$];
    logic [511:0] obs_data[$];
    logic [63:0]  obs_strb[$];
    bit           obs_last[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic bus_idle();
        cmd_if.valid = 1'b0; cmd_if.addr = '0; cmd_if.len = '0;
        data_if.valid = 1'b0; data_if.data = '0; data_if.keep = '0; data_if.last = 1'b0;
        mm_if.awready = 1'b0; mm_if.wready = 1'b0;
        mm_if.bvalid = 1'b0; mm_if.bresp = '0; mm_if.bid = '0; mm_if.buser = '0;
        mm_if.arready = 1'b0; mm_if.rvalid = 1'b0; mm_if.rid = '0; mm_if.rdata = '0;
        mm_if.rresp = '0; mm_if.rlast = 1'b0; mm_if.ruser = '0;
        st_if.ready = 1'b0;
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_cmd_ready"}, cmd_if.ready, 0);
        check({pfx, "_awvalid"}, mm_if.awvalid, 0);
        check({pfx, "_wvalid"}, mm_if.wvalid, 0);
        check({pfx, "_wlast"}, mm_if.wlast, 0);
        check({pfx, "_bready"}, mm_if.bready, 0);
        check({pfx, "_st_valid"}, st_if.valid, 0);
        check({pfx, "_s_ready"}, data_if.ready, 0);
        check({pfx, "_ar_r"}, {mm_if.arvalid, mm_if.rready}, 0);
    endtask

    // Runs one command end to end; rst_beat >= 0 pulses reset after that many W beats.
    task automatic run_cmd(input logic [63:0] a, input logic [31:0] l, input int aw_pct,
                           input int w_mode, input int b_delay, input logic [31:0] emask,
                           input int rst_beat);
        longint unsigned ad, left, pg, b;
        logic exp_err;
        int beats, si, accept_cyc, awv_cyc, status_cyc, last_b_cyc;
        int w_cnt, wlast_cnt, aw_cnt, b_sched, v_order, v_mirror, v_stable, v_attr;
        int q_due[$];
        logic [1:0] q_resp[$];
        bit cmd_pend, done, prev_s_hs, prev_b_hs, aw_hold, st_seen, s_hs, w_hs, b_hs;
        logic [AW-1:0] hold_addr;
        logic [7:0] hold_len, st_first, st_data;

        exp_addr.delete(); exp_len.delete(); exp_last.delete(); pay.delete(); kp.delete();
        obs_addr.delete(); obs_len.delete(); obs_data.delete(); obs_strb.delete(); obs_last.delete();

        ad = a & ((64'd1 << AW) - 1);
        ad = ad & ~64'(BYTES - 1);
        left = (64'(l) + BYTES - 1) / BYTES;
        exp_err = 1'b0;
        while (left > 0) begin
            pg = (4096 - (ad % 4096)) / BYTES;
            b = left;
            if (pg < b) b = pg;
            if (MB < b) b = MB;
            if (exp_addr.size() < 32) exp_err |= emask[exp_addr.size()];
            exp_addr.push_back(ad);
            exp_len.push_back(int'(b) - 1);
            for (longint unsigned k = 0; k < b; k++) exp_last.push_back(k == b - 1);
            ad += b * BYTES;
            left -= b;
        end
        beats = exp_last.size();
        for (int i = 0; i < beats; i++) begin
            pay.push_back(rand512());
            kp.push_back((i == beats - 1 && (l % BYTES) != 0) ? (64'd1 << (l % BYTES)) - 64'd1 : '1);
        end

        si = 0; accept_cyc = -1; awv_cyc = -1; status_cyc = -1; last_b_cyc = -1;
        w_cnt = 0; wlast_cnt = 0; aw_cnt = 0; b_sched = 0;
        v_order = 0; v_mirror = 0; v_stable = 0; v_attr = 0;
        cmd_pend = 1'b1; done = 1'b0; prev_s_hs = 1'b0; prev_b_hs = 1'b0;
        aw_hold = 1'b0; st_seen = 1'b0; st_data = 'x; st_first = '0;
        hold_addr = '0; hold_len = '0;

        for (int t = 0; t < 20000 && !done; t++) begin
            @(negedge clk);
            cyc++;
            cmd_if.valid = cmd_pend; cmd_if.addr = a; cmd_if.len = l;
            if (!data_if.valid || prev_s_hs) begin
                if (si < beats && $urandom_range(0, 3) != 0) begin
                    data_if.valid = 1'b1; data_if.data = pay[si]; data_if.keep = kp[si];
                end else begin
                    data_if.valid = 1'b0;
                end
            end
            case (w_mode)
                0:       mm_if.wready = 1'b1;
                1:       mm_if.wready = 1'($urandom_range(0, 1));
                default: mm_if.wready = ~mm_if.wready;
            endcase
            mm_if.awready = ($urandom_range(0, 99) < aw_pct);
            if (prev_b_hs) mm_if.bvalid = 1'b0;
            if (!mm_if.bvalid && q_due.size() > 0 && q_due[0] <= cyc) begin
                mm_if.bvalid = 1'b1; mm_if.bresp = q_resp[0];
            end
            st_if.ready = 1'($urandom_range(0, 1));
            #1;

            if (!cmd_pend && awv_cyc < 0 && mm_if.awvalid) awv_cyc = cyc;
            if (aw_hold && (!mm_if.awvalid || mm_if.awaddr != hold_addr || mm_if.awlen != hold_len))
                v_stable++;
            if (mm_if.arvalid || mm_if.rready) v_attr++;
            s_hs = data_if.valid && data_if.ready;
            w_hs = mm_if.wvalid && mm_if.wready;
            if (s_hs !== w_hs) v_mirror++;
            if (w_hs) begin
                if (wlast_cnt >= aw_cnt) v_order++;
                obs_data.push_back(mm_if.wdata);
                obs_strb.push_back(mm_if.wstrb);
                obs_last.push_back(mm_if.wlast);
                if (mm_if.wlast) begin
                    wlast_cnt++;
                    q_due.push_back(cyc + 1 + b_delay);
                    q_resp.push_back((b_sched < 32 && emask[b_sched]) ? 2'b10 : 2'b00);
                    b_sched++;
                end
                w_cnt++;
            end
            if (s_hs) si++;
            if (mm_if.awvalid && mm_if.awready) begin
                obs_addr.push_back(64'(mm_if.awaddr));
                obs_len.push_back(int'(mm_if.awlen));
                if (mm_if.awsize != 3'd6 || mm_if.awburst != 2'b01 || mm_if.awid != '0 ||
                    mm_if.awlock || mm_if.awcache != '0 || mm_if.awprot != '0 ||
                    mm_if.awqos != '0 || mm_if.awregion != '0 || mm_if.awuser != '0)
                    v_attr++;
                aw_cnt++;
                aw_hold = 1'b0;
            end else begin
                aw_hold = mm_if.awvalid; hold_addr = mm_if.awaddr; hold_len = mm_if.awlen;
            end
            if (cmd_if.valid && cmd_if.ready) begin
                accept_cyc = cyc; cmd_pend = 1'b0;
            end
            b_hs = mm_if.bvalid && mm_if.bready;
            if (b_hs) begin
                void'(q_due.pop_front()); void'(q_resp.pop_front()); last_b_cyc = cyc;
            end
            prev_b_hs = b_hs;
            if (st_if.valid) begin
                if (!st_seen) begin
                    st_seen = 1'b1; status_cyc = cyc; st_first = st_if.data;
                end else if (st_if.data !== st_first) begin
                    v_stable++;
                end
                if (st_if.ready) begin
                    st_data = st_if.data; done = 1'b1;
                end
            end
            prev_s_hs = s_hs;

            if (rst_beat >= 0 && w_cnt == rst_beat) begin
                #2 rstn = 1'b0;
                #1 check_quiet("mid_rst");
                bus_idle();
                repeat (3) @(negedge clk);
                rstn = 1'b1;
                #1 check("rel_cmd_ready_low", cmd_if.ready, 0);
                @(negedge clk);
                #1 check("rel_cmd_ready_high", cmd_if.ready, 1);
                check("rel_no_status", {st_if.valid, mm_if.awvalid}, 0);
                return;
            end
        end

        @(negedge clk);
        bus_idle();

        check("done", done, 1);
        check("aw_count", obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check($sformatf("awaddr[%0d]", i), obs_addr[i], exp_addr[i]);
            check($sformatf("awlen[%0d]", i), obs_len[i], exp_len[i]);
        end
        check("w_count", obs_data.size(), beats);
        for (int i = 0; i < beats && i < obs_data.size(); i++) begin
            check($sformatf("wdata[%0d]", i), obs_data[i], pay[i]);
            check($sformatf("wstrb[%0d]", i), obs_strb[i], kp[i]);
            check($sformatf("wlast[%0d]", i), obs_last[i], exp_last[i]);
        end
        check("status", st_data, {7'b0, exp_err});
        if (l == 0) begin
            check("status_lat_len0", status_cyc - accept_cyc, 1);
        end else begin
            check("aw_lat", awv_cyc - accept_cyc, 1);
            check("status_after_b", status_cyc - last_b_cyc, 1);
        end
        check("w_before_aw", v_order, 0);
        check("stream_mirror", v_mirror, 0);
        check("valid_stable", v_stable, 0);
        check("aw_attr", v_attr, 0);
    endtask

    initial begin
        bus_idle();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_quiet("reset");
        rstn = 1'b1;
        #1 check("cmd_ready_after_release", cmd_if.ready, 0);
        @(negedge clk);
        #1 check("cmd_ready_rise", cmd_if.ready, 1);

        run_cmd(64'h1000, 32'd4096, 100, 0, 0, 32'h0, -1);
        run_cmd(64'h0FC0, 32'd200, 70, 1, 2, 32'h0, -1);
        run_cmd(64'h0, 32'd2048, 100, 0, 50, 32'h0, -1);
        run_cmd(64'h0, 32'd8192, 100, 1, 50, 32'h0, -1);
        run_cmd(64'h10000, 32'd12288, 80, 1, 3, 32'h2, -1);
        run_cmd(64'h20000, 32'd256, 80, 1, 0, 32'h0, -1);
        run_cmd(64'h1234, 32'd0, 100, 0, 0, 32'h0, -1);
        run_cmd(64'h40, 32'd1000, 100, 2, 1, 32'h0, -1);
        run_cmd(64'h0, 32'd4096, 100, 0, 0, 32'h0, 10);
        run_cmd(64'h2000, 32'd64, 100, 0, 0, 32'h0, -1);

        for (int r = 0; r < 8; r++) begin
            logic [63:0] ra;
            logic [31:0] rl;
            logic [31:0] rm;
            ra = {$urandom, $urandom};
            ra[32] = 1'b0;
            rl = $urandom_range(1, 12000);
            rm = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
            run_cmd(ra, rl, $urandom_range(30, 100), $urandom_range(0, 2),
                    $urandom_range(0, 6), rm, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
